stopwatch_bcd_cnt: RTL and testbench

Stopwatch time base and BCD digit counter for the watch design. It synchronizes the start/stop and clear buttons and runs a run/stop state machine. It divides the system clock into 0.1 s ticks and counts three BCD digits (tenths, seconds ones, seconds tens) from 00.0 to 59.9. Each digit output feeds one hex2led segment decoder directly upstream of the display. Outputs never exceed 9 (tens never exceed 5), so the decoder's blank codes 10–15 are never driven.

---
 rtl/stopwatch_bcd_cnt_pkg.sv | 25 ++
 rtl/stopwatch_bcd_cnt_bcd_digit.sv | 34 +++
 rtl/stopwatch_bcd_cnt.sv | 161 ++++++++++++++++
 tb/tb_stopwatch_bcd_cnt.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_bcd_cnt_pkg.sv
// Shared types and constants for the stopwatch time base and BCD digit chain.
package stopwatch_pkg;

   typedef enum logic {
      STOPPED = 1'b0,
      RUNNING = 1'b1
   } state_t;

   typedef logic [3:0] bcd_t;

   localparam bcd_t DIGIT_MAX = 4'd9;
   localparam bcd_t TENS_MAX  = 4'd5;

   // Next BCD value; anything at or beyond max (including corrupted codes) returns to 0.
   function automatic bcd_t bcd_next(input bcd_t d, input bcd_t max);
      bcd_t n;
      if (d >= max) begin
         n = 4'd0;
      end else begin
         n = d + 4'd1;
      end
      return n;
   endfunction

endpackage

// File: rtl/stopwatch_bcd_cnt_bcd_digit.sv
// One BCD digit of the stopwatch chain; carry is combinational so a whole
// ripple of carries lands on a single clock edge.
module bcd_digit
   import stopwatch_pkg::*;
#(
   parameter bcd_t MAX = DIGIT_MAX
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] digit,
   output logic       carry
);

   bcd_t digit_r;

   // Digit register: clear has priority over increment.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         digit_r <= 4'd0;
      end else if (clr) begin
         digit_r <= 4'd0;
      end else if (inc) begin
         digit_r <= bcd_next(digit_r, MAX);
      end else begin
         digit_r <= digit_r;
      end
   end

   assign digit = digit_r;
   assign carry = inc & (digit_r == MAX);

endmodule

// File: rtl/stopwatch_bcd_cnt.sv
// Stopwatch top: button synchronizers, run/stop FSM, 0.1 s prescaler and a
// three-digit BCD count 00.0..59.9 that wraps silently.
module stopwatch_bcd_cnt
   import stopwatch_pkg::*;
#(
   parameter int CLK_DIV = 1000000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       strtstop,
   input  logic       clr,
   output logic [3:0] tenths,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic       running,
   output logic       tick
);

   localparam int PRE_W = $clog2(CLK_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

   logic             s1_r, s2_r, s3_r;
   logic             c1_r, c2_r;
   logic             ss_edge_s;
   logic             clr_s;
   state_t           state_r;
   logic [PRE_W-1:0] pre_r;
   logic             running_r;
   logic             tick_r;
   logic             pre_wrap_s;
   logic             inc_s;
   logic             dig_clr_s;
   logic             tenths_carry_s;
   logic             ones_carry_s;
   logic             wrap_unused_s;

   // Button synchronizers; the third strtstop stage feeds the rising-edge detect.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_r <= 1'b0;
         s2_r <= 1'b0;
         s3_r <= 1'b0;
         c1_r <= 1'b0;
         c2_r <= 1'b0;
      end else begin
         s1_r <= strtstop;
         s2_r <= s1_r;
         s3_r <= s2_r;
         c1_r <= clr;
         c2_r <= c1_r;
      end
   end

   assign ss_edge_s  = s2_r & ~s3_r;
   assign clr_s      = c2_r;
   assign pre_wrap_s = (pre_r == PRE_LAST);

   // Increment and clear strobes for the digit chain, decoded from the current state.
   always_comb begin
      inc_s     = 1'b0;
      dig_clr_s = 1'b0;
      case (state_r)
         STOPPED: begin
            inc_s     = 1'b0;
            dig_clr_s = clr_s;
         end
         RUNNING: begin
            // A stop edge coinciding with the last prescaler count swallows the tick.
            inc_s     = pre_wrap_s & ~ss_edge_s;
            dig_clr_s = 1'b0;
         end
         default: begin
            inc_s     = 1'b0;
            dig_clr_s = 1'b0;
         end
      endcase
   end

   // Run/stop FSM with prescaler and registered running/tick outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= STOPPED;
         pre_r     <= {PRE_W{1'b0}};
         running_r <= 1'b0;
         tick_r    <= 1'b0;
      end else begin
         case (state_r)
            STOPPED: begin
               if (ss_edge_s) begin
                  state_r   <= RUNNING;
                  running_r <= 1'b1;
               end else begin
                  state_r   <= STOPPED;
                  running_r <= 1'b0;
               end
               if (clr_s) begin
                  pre_r <= {PRE_W{1'b0}};
               end else begin
                  pre_r <= pre_r;
               end
               tick_r <= 1'b0;
            end
            RUNNING: begin
               if (ss_edge_s) begin
                  // Prescaler holds so a resumed run finishes the partial tenth.
                  state_r   <= STOPPED;
                  running_r <= 1'b0;
                  pre_r     <= pre_r;
               end else begin
                  state_r   <= RUNNING;
                  running_r <= 1'b1;
                  if (pre_wrap_s) begin
                     pre_r <= {PRE_W{1'b0}};
                  end else begin
                     pre_r <= pre_r + {{(PRE_W-1){1'b0}}, 1'b1};
                  end
               end
               tick_r <= inc_s;
            end
            default: begin
               state_r   <= STOPPED;
               running_r <= 1'b0;
               pre_r     <= {PRE_W{1'b0}};
               tick_r    <= 1'b0;
            end
         endcase
      end
   end

   bcd_digit #(.MAX(DIGIT_MAX)) u_tenths (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (dig_clr_s),
      .inc     (inc_s),
      .digit   (tenths),
      .carry   (tenths_carry_s)
   );

   bcd_digit #(.MAX(DIGIT_MAX)) u_sec_ones (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (dig_clr_s),
      .inc     (tenths_carry_s),
      .digit   (sec_ones),
      .carry   (ones_carry_s)
   );

   // The tens carry marks the 59.9 -> 00.0 wrap, which is deliberately not reported.
   bcd_digit #(.MAX(TENS_MAX)) u_sec_tens (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (dig_clr_s),
      .inc     (ones_carry_s),
      .digit   (sec_tens),
      .carry   (wrap_unused_s)
   );

   assign running = running_r;
   assign tick    = tick_r;

endmodule

// File: tb/tb_stopwatch_bcd_cnt.sv
// Self-checking bench: directed scenarios plus random button activity, all
// compared every cycle against a count-in-tenths behavioural model.
module tb_stopwatch_bcd_cnt;

   localparam int CLK_DIV = 4;

   logic       clk      = 1'b0;
   logic       reset_n  = 1'b1;
   logic       strtstop = 1'b0;
   logic       clr      = 1'b0;
   logic [3:0] tenths, sec_ones, sec_tens;
   logic       running, tick;

   int   n_chk  = 0;
   int   n_fail = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   stopwatch_bcd_cnt #(.CLK_DIV(CLK_DIV)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .strtstop (strtstop),
      .clr      (clr),
      .tenths   (tenths),
      .sec_ones (sec_ones),
      .sec_tens (sec_tens),
      .running  (running),
      .tick     (tick)
   );

   // Model: count held as an integer number of tenths, phase within the tenth,
   // button levels as seen two and three edges ago.
   logic [2:0] m_ss;
   logic [1:0] m_cl;
   int         m_cnt, m_ph;
   logic       m_run, m_tick;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_ss <= 3'b000; m_cl <= 2'b00; m_cnt <= 0; m_ph <= 0;
         m_run <= 1'b0; m_tick <= 1'b0;
      end else begin
         m_ss   <= {m_ss[1:0], strtstop};
         m_cl   <= {m_cl[0], clr};
         m_tick <= 1'b0;
         if (!m_run) begin
            if (m_ss[1] && !m_ss[2]) m_run <= 1'b1;
            if (m_cl[1]) begin m_cnt <= 0; m_ph <= 0; end
         end else if (m_ss[1] && !m_ss[2]) begin
            m_run <= 1'b0;
         end else if (m_ph == CLK_DIV - 1) begin
            m_ph <= 0; m_cnt <= (m_cnt + 1) % 600; m_tick <= 1'b1;
         end else begin
            m_ph <= m_ph + 1;
         end
      end
   end

   always @(negedge clk) begin
      logic [11:0] e;
      if (chk_en) begin
         e = {4'(m_cnt / 100), 4'((m_cnt / 10) % 10), 4'(m_cnt % 10)};
         n_chk++;
         if ({sec_tens, sec_ones, tenths, running, tick} !== {e, m_run, m_tick}) begin
            n_fail++;
            $display("FAIL model t=%0t: got %h run=%b tick=%b expected %h run=%b tick=%b",
                     $time, {sec_tens, sec_ones, tenths}, running, tick, e, m_run, m_tick);
         end
      end
   end

   function automatic logic [11:0] disp();
      return {sec_tens, sec_ones, tenths};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int n);
      strtstop = 1'b1;
      cyc(n);
      strtstop = 1'b0;
   endtask

   // Cycles until the next tick, bounded.
   task automatic wait_tick(output int c);
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!tick && c < 40);
   endtask

   task automatic ticks(input int n);
      int c, got;
      got = 0;
      for (int i = 0; i < n; i++) begin
         wait_tick(c);
         if (tick) got++;
      end
      check("tick count reached", got, n);
   endtask

   initial begin
      int   c, b, tog;
      logic prev;
      logic [11:0] d0;

      #1 reset_n = 1'b0;
      cyc(3);
      reset_n = 1'b1;
      chk_en  = 1'b1;
      check("reset digits", disp(), 12'h000);
      check("reset running", running, 1'b0);

      // Start: running changes after the third edge.
      strtstop = 1'b1;
      cyc(1);
      check("start edge1", running, 1'b0);
      cyc(1);
      strtstop = 1'b0;
      check("start edge2", running, 1'b0);
      cyc(1);
      check("start edge3", running, 1'b1);
      wait_tick(c);
      check("first tick latency", c, CLK_DIV);
      ticks(9);
      check("10 ticks", disp(), 12'h010);
      wait_tick(c);
      check("tick period", c, CLK_DIV);
      ticks(89);
      check("100 ticks", disp(), 12'h100);
      ticks(23);
      check("123 ticks", disp(), 12'h123);

      // Asynchronous reset mid-run, observed between edges.
      #2 reset_n = 1'b0;
      #1;
      check("async reset digits", disp(), 12'h000);
      check("async reset running", running, 1'b0);
      check("async reset tick", tick, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      cyc(20);
      check("idle after reset", disp(), 12'h000);
      check("idle running", running, 1'b0);

      // Wrap 59.9 -> 00.0 -> 00.1.
      press(2);
      cyc(1);
      ticks(599);
      check("reach 59.9", disp(), 12'h599);
      ticks(1);
      check("wrap to 00.0", disp(), 12'h000);
      check("running after wrap", running, 1'b1);
      ticks(1);
      check("after wrap 00.1", disp(), 12'h001);

      // Stop at 01.3 with prescaler at 2, hold, resume with clr ignored.
      ticks(12);
      press(2);
      cyc(1);
      check("stopped", running, 1'b0);
      check("model pre at stop", m_ph, 2);
      cyc(50);
      check("hold 01.3", disp(), 12'h013);
      press(2);
      cyc(1);
      check("resumed", running, 1'b1);
      clr = 1'b1;
      wait_tick(c);
      check("resume tick latency", c, 2);
      check("resume count 01.4", disp(), 12'h014);
      cyc(6);
      clr = 1'b0;

      // Clear while stopped at 07.5.
      b = 0;
      do begin @(negedge clk); b++; end while (!(m_cnt == 75 && m_tick) && b < 1000);
      check("reach 07.5", disp(), 12'h075);
      press(2);
      cyc(1);
      check("stopped at 07.5", running, 1'b0);
      clr = 1'b1;
      cyc(2);
      check("clear edge2", disp(), 12'h075);
      cyc(1);
      check("clear edge3", disp(), 12'h000);
      check("model pre cleared", m_ph, 0);
      clr = 1'b0;
      cyc(3);

      // Clear and start edge together; prescaler must restart from 0.
      press(2);
      cyc(1);
      ticks(3);
      press(2);
      cyc(2);
      check("stopped at 00.3", disp(), 12'h003);
      strtstop = 1'b1;
      clr      = 1'b1;
      cyc(2);
      strtstop = 1'b0;
      cyc(1);
      check("clear+start digits", disp(), 12'h000);
      check("clear+start running", running, 1'b1);
      clr = 1'b0;
      wait_tick(c);
      check("tick after clear+start", c, CLK_DIV);

      // Held button: exactly one toggle.
      strtstop = 1'b1;
      tog  = 0;
      prev = running;
      repeat (100) begin
         @(negedge clk);
         if (running != prev) tog++;
         prev = running;
      end
      strtstop = 1'b0;
      check("held toggles", tog, 1);
      check("held stopped", running, 1'b0);
      cyc(3);

      // Stop edge coincident with the last prescaler count.
      press(2);
      cyc(1);
      check("collision start", running, 1'b1);
      wait_tick(c);
      d0 = disp();
      cyc(1);
      strtstop = 1'b1;
      cyc(2);
      strtstop = 1'b0;
      cyc(1);
      check("collision no inc", disp(), d0);
      check("collision stopped", running, 1'b0);
      check("collision no tick", tick, 1'b0);
      check("model pre at collision", m_ph, CLK_DIV - 1);
      cyc(2);
      press(2);
      cyc(1);
      check("collision resume", running, 1'b1);
      wait_tick(c);
      check("tick first edge after resume", c, 1);

      // Random button activity with occasional asynchronous resets.
      repeat (300) begin
         if ($urandom_range(0, 39) == 0) begin
            #2 reset_n = 1'b0;
            cyc(1);
            reset_n = 1'b1;
         end else begin
            strtstop = 1'($urandom_range(0, 1));
            clr      = ($urandom_range(0, 3) == 0);
            cyc($urandom_range(1, 12));
         end
      end
      strtstop = 1'b0;
      clr      = 1'b0;
      cyc(4);
      chk_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
